// File: rtl/ad9634_spi_pkg.sv
// Shared definitions for the AD9634-style SPI register target: instruction
// layout, transfer-length encodings, FSM states and fixed addresses.
package ad9634_spi_pkg;

  localparam int INSTR_W  = 16;
  localparam int RW_POS   = 15;
  localparam int W_HI_POS = 14;
  localparam int W_LO_POS = 13;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;

  // W1:W0 transfer length encodings
  localparam logic [1:0] W_ONE    = 2'b00;
  localparam logic [1:0] W_TWO    = 2'b01;
  localparam logic [1:0] W_THREE  = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_CHIP_ID   = 13'h001;
  localparam logic [ADDR_W-1:0] ADDR_XFER      = 13'h0FF;
  localparam logic [ADDR_W-1:0] ADDR_SHADOW_LO = 13'h008;

  localparam logic [DATA_W-1:0] CHIP_ID_DEFAULT = 8'h87;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the SPI pins into clk and produces single-cycle sclk/cs edge
// strobes. A CS fall is only reported once CS has been seen high after reset.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic cs_n_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic mosi_o,
  output logic cs_n_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;
  logic                   sclk_s;
  logic                   cs_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      // fill_q marks when cs_s holds a real pin sample rather than the reset value
      if (fill_q[SYNC_STAGES-1] && cs_s) armed_q <= 1'b1;
    end
  end

  assign sclk_rise_o = sclk_s & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_s & sclk_prev_q;
  assign cs_fall_o   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise_o   = cs_s & ~cs_prev_q;
  assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_o      = cs_s;

endmodule

// File: rtl/ad9634_spi_target.sv
// SPI mode-0 register target with 16-bit instruction phase and auto-decrementing
// address. Define AD9634_XFER_REG_EN to stage writes at 0x008+ in a shadow bank.
module ad9634_spi_target
  import ad9634_spi_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter int              NUM_REGS    = 32,
  parameter logic [7:0]      CHIP_ID     = CHIP_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_cs_n,
  output logic        reg_wr_stb,
  output logic [12:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, cs_n_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sclk_i      (spi_sclk),
    .mosi_i      (spi_mosi),
    .cs_n_i      (spi_cs_n),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .mosi_o      (mosi_s),
    .cs_n_o      (cs_n_s)
  );

  state_e              state_q;
  logic [3:0]          bit_cnt_q;
  logic [14:0]         instr_q;
  logic [6:0]          rx_q;
  logic [7:0]          tx_q;
  logic                rd_q;
  logic [1:0]          wmode_q;
  logic [1:0]          bytes_left_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                load_pend_q;
  logic                miso_q;
  logic                wr_stb_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   live_q [NUM_REGS];

  logic [INSTR_W-1:0]  instr_full;
  logic [DATA_W-1:0]   rx_full;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_ok;

  assign instr_full = {instr_q, mosi_s};
  assign rx_full    = {rx_q, mosi_s};

  always_comb begin
    rd_data = '0;
    if (addr_q == ADDR_CHIP_ID)    rd_data = CHIP_ID;
    else if (addr_q < NUM_REGS_A)  rd_data = live_q[addr_q[IDX_W-1:0]];
  end

  always_comb begin
    wr_ok = (addr_q < NUM_REGS_A) && (addr_q != ADDR_CHIP_ID);
`ifdef AD9634_XFER_REG_EN
    if (addr_q == ADDR_XFER) wr_ok = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      instr_q      <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      rd_q         <= 1'b0;
      wmode_q      <= W_ONE;
      bytes_left_q <= '0;
      addr_q       <= '0;
      load_pend_q  <= 1'b0;
      miso_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      // CS release wins over any sclk edge seen in the same cycle
      if (cs_rise) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state_q     <= ST_INSTR;
              bit_cnt_q   <= '0;
              load_pend_q <= 1'b0;
            end
          end
          ST_INSTR: begin
            if (sclk_rise) begin
              instr_q   <= instr_full[14:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                state_q      <= ST_DATA;
                bit_cnt_q    <= '0;
                rd_q         <= instr_full[RW_POS];
                wmode_q      <= instr_full[W_HI_POS:W_LO_POS];
                bytes_left_q <= instr_full[W_HI_POS:W_LO_POS];
                addr_q       <= instr_full[ADDR_W-1:0];
                load_pend_q  <= instr_full[RW_POS];
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx_q      <= rx_full[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                addr_q    <= addr_q - 13'd1;
                if (!rd_q && wr_ok) begin
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= rx_full;
                end
                if (wmode_q != W_STREAM && bytes_left_q == 2'd0) begin
                  state_q <= ST_DONE;
                end else begin
                  bytes_left_q <= bytes_left_q - 2'd1;
                  load_pend_q  <= rd_q;
                end
              end
            end else if (sclk_fall && rd_q) begin
              if (load_pend_q) begin
                miso_q      <= rd_data[7];
                tx_q        <= {rd_data[6:0], 1'b0};
                load_pend_q <= 1'b0;
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
          end
          ST_DONE: miso_q <= 1'b0;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef AD9634_XFER_REG_EN
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else if (wr_stb_q) begin
      // The transfer bit is acted on here and never stored, so it reads back 0
      if (wr_addr_q == ADDR_XFER) begin
        if (wr_data_q[0]) begin
          for (int i = int'(ADDR_SHADOW_LO); i < NUM_REGS; i++) live_q[i] <= shadow_q[i];
        end
      end else if (wr_addr_q >= ADDR_SHADOW_LO) begin
        shadow_q[wr_addr_q[IDX_W-1:0]] <= wr_data_q;
      end else begin
        live_q[wr_addr_q[IDX_W-1:0]] <= wr_data_q;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) live_q[i] <= '0;
    end else if (wr_stb_q) begin
      live_q[wr_addr_q[IDX_W-1:0]] <= wr_data_q;
    end
  end
`endif

  assign spi_miso    = miso_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = ~cs_n_s;

endmodule

// File: tb/tb_ad9634_spi_target.sv
// Bench for ad9634_spi_target: directed vector table, multi-cycle corner cases and
// random transfers against a register-map model. Honors AD9634_XFER_REG_EN.
module tb_ad9634_spi_target;
  import ad9634_spi_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int H        = 6;

  logic        clk, rst_n, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic        reg_wr_stb, busy;
  logic [12:0] reg_wr_addr;
  logic [7:0]  reg_wr_data;

  int checks   = 0;
  int failures = 0;

  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  logic [7:0]  m_live   [NUM_REGS];
  logic [7:0]  m_shadow [NUM_REGS];

  typedef struct packed {
    logic [15:0] instr;
    logic [2:0]  nbytes;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [2:0]  exp_nstb;
  } vec_t;
  vec_t vec_q[$];

  ad9634_spi_target #(.SYNC_STAGES(2), .NUM_REGS(NUM_REGS), .CHIP_ID(8'h87)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (rst_n && reg_wr_stb === 1'b1) got_q.push_back({reg_wr_addr, reg_wr_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // register-map model
  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_live[i]   = 8'h00;
      m_shadow[i] = 8'h00;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [12:0] a);
    if (a == 13'h001) return 8'h87;
    if (a < 13'(NUM_REGS)) return m_live[a];
    return 8'h00;
  endfunction

  task automatic m_write(input logic [12:0] a, input logic [7:0] d);
`ifdef AD9634_XFER_REG_EN
    if (a == 13'h0FF) begin
      exp_q.push_back({a, d});
      if (d[0]) for (int i = 8; i < NUM_REGS; i++) m_live[i] = m_shadow[i];
    end else if (a < 13'(NUM_REGS) && a != 13'h001) begin
      exp_q.push_back({a, d});
      if (a >= 13'h008) m_shadow[a] = d;
      else m_live[a] = d;
    end
`else
    if (a < 13'(NUM_REGS) && a != 13'h001) begin
      exp_q.push_back({a, d});
      m_live[a] = d;
    end
`endif
  endtask

  // drivers
  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    spi_mosi = b;
    repeat (H) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [15:0] instr, input int nbits, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    logic m;
    rdata = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(instr[15-i], m);
    for (int j = 0; j < nbits; j++) begin
      spi_bit(wdata[8*(j/8) + 7 - (j%8)], m);
      rdata[8*(j/8) + 7 - (j%8)] = m;
    end
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic check_stbs(input string name);
    check({name, ":stb_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, ":stb"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input string name, input logic [15:0] instr, input int nbytes,
                         input logic [31:0] wdata, output logic [31:0] rd, output int nstb);
    logic [31:0] exp_rd;
    logic [12:0] a;
    logic        active;
    exp_rd = '0;
    for (int i = 0; i < nbytes; i++) begin
      a      = instr[12:0] - 13'(i);
      active = (instr[14:13] == 2'b11) || (i <= int'(instr[14:13]));
      if (active) begin
        if (instr[15]) exp_rd[8*i +: 8] = m_read(a);
        else m_write(a, wdata[8*i +: 8]);
      end
    end
    spi_xfer(instr, nbytes * 8, wdata, rd);
    nstb = got_q.size();
    check({name, ":miso"}, rd, exp_rd);
    check_stbs(name);
  endtask

  task automatic add_vec(input logic [15:0] instr, input logic [2:0] nb, input logic [31:0] wd,
                         input logic [31:0] er, input logic [2:0] ns);
    vec_q.push_back('{instr, nb, wd, er, ns});
  endtask

  initial begin
    logic [31:0] rd;
    logic        m;
    int          nstb;
    logic [1:0]  w;
    logic        rw;
    logic [12:0] a;
    int          nb;
    int          sel;

    rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_stb",  32'(reg_wr_stb), 32'h0);
    check("rst_addr", 32'(reg_wr_addr), 32'h0);
    check("rst_data", 32'(reg_wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // directed vector table: instr, bytes, write data, expected read bytes, expected strobes
    add_vec(16'h0014, 3'd1, 32'h000000A5, 32'h00000000, 3'd1);
`ifdef AD9634_XFER_REG_EN
    add_vec(16'h00FF, 3'd1, 32'h00000001, 32'h00000000, 3'd1);
`endif
    add_vec(16'h8014, 3'd1, 32'h0,        32'h000000A5, 3'd0);
    add_vec(16'h8001, 3'd1, 32'h0,        32'h00000087, 3'd0);
    add_vec(16'h4010, 3'd3, 32'h00332211, 32'h00000000, 3'd3);
`ifdef AD9634_XFER_REG_EN
    add_vec(16'h00FF, 3'd1, 32'h00000001, 32'h00000000, 3'd1);
`endif
    add_vec(16'hC010, 3'd3, 32'h0,        32'h00332211, 3'd0);
    add_vec(16'h0001, 3'd1, 32'h00000055, 32'h00000000, 3'd0);
    add_vec(16'h8001, 3'd1, 32'h0,        32'h00000087, 3'd0);
    add_vec(16'h0020, 3'd1, 32'h00000099, 32'h00000000, 3'd0);
    add_vec(16'h8020, 3'd1, 32'h0,        32'h00000000, 3'd0);
    add_vec(16'h2000, 3'd2, 32'h00006677, 32'h00000000, 3'd1);
    add_vec(16'hA000, 3'd2, 32'h0,        32'h00000077, 3'd0);
    add_vec(16'h6003, 3'd4, 32'hA4A3A2A1, 32'h00000000, 3'd3);
    add_vec(16'hE003, 3'd4, 32'h0,        32'hA487A2A1, 3'd0);
    add_vec(16'h0005, 3'd2, 32'h00005A3C, 32'h00000000, 3'd1);
    add_vec(16'h8005, 3'd2, 32'h0,        32'h0000003C, 3'd0);
    add_vec(16'h8004, 3'd1, 32'h0,        32'h00000000, 3'd0);
`ifdef AD9634_XFER_REG_EN
    add_vec(16'h00FF, 3'd1, 32'h00000001, 32'h00000000, 3'd1);
`else
    add_vec(16'h00FF, 3'd1, 32'h00000001, 32'h00000000, 3'd0);
`endif
    add_vec(16'h80FF, 3'd1, 32'h0,        32'h00000000, 3'd0);

    for (int i = 0; i < vec_q.size(); i++) begin
      run_txn($sformatf("vec%0d", i), vec_q[i].instr, int'(vec_q[i].nbytes), vec_q[i].wdata, rd, nstb);
      check($sformatf("vec%0d:tbl_rd", i), rd, vec_q[i].exp_rd);
      check($sformatf("vec%0d:tbl_nstb", i), 32'(nstb), 32'(vec_q[i].exp_nstb));
    end

    // CS released after 4 data bits of a write to 0x005
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(1'(16'h0005 >> (15 - i)), m);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
    check("abort:stb_count", 32'(got_q.size()), 32'h0);
    check("abort:state", 32'(dut.state_q), 32'(ST_IDLE));
    check("abort:busy", 32'(busy), 32'h0);
    got_q.delete();
    run_txn("abort_rd", 16'h8005, 1, 32'h0, rd, nstb);
    check("abort_rd:val", rd, 32'h3C);

    // CS rises in the same cycle as the 8th data rise of a write to 0x007
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(1'(16'h0007 >> (15 - i)), m);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, m);
    @(negedge clk);
    spi_mosi = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b1;
    spi_cs_n = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (2*H) @(negedge clk);
    check("cs_prio:stb_count", 32'(got_q.size()), 32'h0);
    got_q.delete();
    run_txn("cs_prio_rd", 16'h8007, 1, 32'h0, rd, nstb);
    check("cs_prio_rd:val", rd, 32'h0);

    // reset asserted mid-read of the chip ID
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(1'(16'h8001 >> (15 - i)), m);
    repeat (H) @(negedge clk);
    check("rst_mid:miso_before", 32'(spi_miso), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid:miso", 32'(spi_miso), 32'h0);
    check("rst_mid:busy", 32'(busy), 32'h0);
    spi_cs_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();
    run_txn("rst_rd14", 16'h8014, 1, 32'h0, rd, nstb);
    check("rst_rd14:val", rd, 32'h0);

    // CS already low when reset releases: no transfer until a fresh fall
    @(negedge clk);
    rst_n = 1'b0;
    spi_cs_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(1'(16'h0006 >> (15 - i)), m);
    for (int i = 0; i < 8; i++) spi_bit(1'(8'h3C >> (7 - i)), m);
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
    check("stale_cs:stb_count", 32'(got_q.size()), 32'h0);
    got_q.delete();
    run_txn("stale_cs_rd", 16'h8006, 1, 32'h0, rd, nstb);
    check("stale_cs_rd:val", rd, 32'h0);

`ifdef AD9634_XFER_REG_EN
    run_txn("x_wr8", 16'h0008, 1, 32'h5A, rd, nstb);
    check("x_wr8:nstb", 32'(nstb), 32'h1);
    run_txn("x_rd8a", 16'h8008, 1, 32'h0, rd, nstb);
    check("x_rd8a:val", rd, 32'h0);
    run_txn("x_go", 16'h00FF, 1, 32'h01, rd, nstb);
    check("x_go:nstb", 32'(nstb), 32'h1);
    run_txn("x_rd8b", 16'h8008, 1, 32'h0, rd, nstb);
    check("x_rd8b:val", rd, 32'h5A);
    run_txn("x_rdff", 16'h80FF, 1, 32'h0, rd, nstb);
    check("x_rdff:val", rd, 32'h0);
`endif

    // random transfers against the model
    for (int n = 0; n < 30; n++) begin
      rw  = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 13'($urandom_range(0, 40));
      else if (sel == 8) a = 13'h0FF;
      else               a = 13'($urandom_range(0, 2));
      if (w == 2'b11) nb = int'($urandom_range(1, 4));
      else begin
        nb = int'(w) + 1 + int'($urandom_range(0, 1));
        if (nb > 4) nb = 4;
      end
      run_txn($sformatf("rnd%0d", n), {rw, w, a}, nb, $urandom, rd, nstb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad9634_spi_target.md
AD9634_SPI_TARGET -- requirements
Module: ad9634_spi_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for spi_sclk, spi_mosi and spi_cs_n; legal range 2-3.
REQ-002 Parameter NUM_REGS, default 32: implemented register locations, addresses 0x000 to NUM_REGS-1.
REQ-003 Parameter CHIP_ID, default 8'h87: read-only value at address 0x001.
REQ-004 Port clk, input, 1: the single system clock; spi_sclk is sampled data, not a clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port spi_sclk, input, 1: SPI clock from the controller, mode 0 (CPOL=0, CPHA=0).
REQ-007 Port spi_mosi, input, 1: serial data from the controller, MSB first.
REQ-008 Port spi_miso, output, 1: serial read data to the controller.
REQ-009 Port spi_cs_n, input, 1: active-low chip select.
REQ-010 Port reg_wr_stb, output, 1: one-clk pulse per committed register write.
REQ-011 Port reg_wr_addr, output, 13: address of the committed write.
REQ-012 Port reg_wr_data, output, 8: data of the committed write.
REQ-013 Port busy, output, 1: high while synchronized spi_cs_n is low.

Function
REQ-014 The block SHALL detect spi_sclk rise and fall edges after the synchronizer, in clk; the supported spi_sclk frequency is at most clk/8.
REQ-015 The block SHALL sample spi_mosi on each detected rise and SHALL update spi_miso on each detected fall.
REQ-016 Instruction format: 16 bits; bit15 = R/nW (1 = read); bits14:13 = W1:W0 (00/01/10 = 1/2/3 data bytes, 11 = stream until CS rises); bits12:0 = start address.
REQ-017 FSM states: IDLE -> INSTR on the CS falling edge; INSTR -> DATA after 16 rises; DATA -> DONE once the byte count completes (non-stream only); any state -> IDLE on the CS rising edge.
REQ-018 In DONE, further spi_sclk edges SHALL be ignored and spi_miso SHALL be held at 0.
REQ-019 Address SHALL decrement by 1 after each data byte and wrap from 0x0000 to 0x1FFF.
REQ-020 Write: on the 8th rise of a data byte, the register SHALL be updated and reg_wr_stb SHALL pulse with address and data, 1 clk after rise detection.
REQ-021 Read: the register at the current address SHALL be loaded into the shift register on the fall after the last instruction rise or the last rise of the previous byte; MSB is driven first.
REQ-022 Reads of unimplemented addresses SHALL return 0x00; writes to them and to 0x001 SHALL be ignored, with no reg_wr_stb.
REQ-023 If CS rises mid-byte, the partial byte SHALL be discarded with no write.
REQ-024 spi_miso SHALL be 0 in IDLE, INSTR, DONE and during write transfers.
REQ-025 If CS rises and a spi_sclk edge occur in the same clk, CS SHALL take priority.

Reset
REQ-026 While rst_n is low: FSM = IDLE, spi_miso = 0, reg_wr_stb = 0, reg_wr_addr = 0, reg_wr_data = 0, busy = 0, synchronizers cleared to the idle levels sclk = 0 and cs_n = 1, all registers = 0x00.
REQ-027 After reset, the first transfer SHALL begin only on a fresh CS falling edge.

Configuration
REQ-028 Macro AD9634_XFER_REG_EN defined: writes to 0x008 to NUM_REGS-1 SHALL go to a shadow copy.
REQ-029 With AD9634_XFER_REG_EN defined: a write of bit0 = 1 to 0x0FF SHALL copy the shadow to the live registers in one clk; bit0 SHALL self-clear and read back 0.
REQ-030 With AD9634_XFER_REG_EN defined: reads SHALL return live values, and reg_wr_stb SHALL fire on the shadow write.
REQ-031 Macro AD9634_XFER_REG_EN undefined: writes SHALL update live registers directly, and 0x0FF SHALL behave as unimplemented.

Structure
REQ-032 Shared package ad9634_spi_pkg SHALL hold: instruction field widths and positions, W1:W0 encodings, FSM state enum, address constants 0x001 and 0x0FF, and CHIP_ID default.
REQ-033 One sub-module, spi_edge_sync, SHALL contain the synchronizers and the rise/fall/CS-edge detectors.

Verification
REQ-034 Write 0x0014, W = 00, data 0xA5 -> one reg_wr_stb with addr 0x014 and data 0xA5; a readback of 0x014 returns 0xA5.
REQ-035 Read 0x0001 -> spi_miso shifts 0x87 MSB first; no reg_wr_stb.
REQ-036 Write, W = 10, address 0x0010, data 0x11 0x22 0x33 -> writes land at 0x010, 0x00F and 0x00E.
REQ-037 Write 0x0005, CS raised after 4 data bits -> no reg_wr_stb, register unchanged, FSM in IDLE.
REQ-038 rst_n asserted mid-read of 0x0001 -> spi_miso = 0 immediately; a following read of 0x0014 returns 0x00.
REQ-039 AD9634_XFER_REG_EN defined: write 0x5A to 0x008 -> readback 0x00; write 0x01 to 0x0FF -> readback of 0x008 returns 0x5A and 0x0FF reads 0x00.
